// File: rtl/pe_nz_scheduler.sv
// Non-zero lane scheduler: packs the set-bit indices of a node's feature mask into
// groups of up to MAC_DIM lane addresses for the downstream PE, one group per cycle.
module pe_nz_scheduler #(
  parameter int MAC_DIM    = 6,
  parameter int SPAD_WIDTH = 64,
  parameter int ADDR_WIDTH = 6,
  parameter int TAG_WIDTH  = 12
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [SPAD_WIDTH-1:0]          nz_mask,
  input  logic [TAG_WIDTH-1:0]           tag_in,
  output logic                           ready,
  output logic                           issue_vld,
  output logic [ADDR_WIDTH*MAC_DIM-1:0]  nz_addr_out,
  output logic [2:0]                     nz_num,
  output logic                           acc,
  output logic                           done,
  output logic [TAG_WIDTH-1:0]           tag_out,
  output logic                           empty_vld
);

  logic [SPAD_WIDTH-1:0]         rem_q, rem_d;
  logic                          issue_vld_q, issue_vld_d;
  logic [ADDR_WIDTH*MAC_DIM-1:0] nz_addr_q, nz_addr_d;
  logic [2:0]                    nz_num_q, nz_num_d;
  logic                          acc_q, acc_d;
  logic                          done_q, done_d;
  logic [TAG_WIDTH-1:0]          tag_q, tag_d;
  logic                          empty_vld_q, empty_vld_d;

  logic [SPAD_WIDTH-1:0] src;
  logic [SPAD_WIDTH-1:0] work;
  logic                  found;
  int unsigned           cnt;

  assign ready = (rem_q == '0);

  always_comb begin
    rem_d       = rem_q;
    issue_vld_d = 1'b0;
    nz_addr_d   = '0;
    nz_num_d    = '0;
    acc_d       = 1'b0;
    done_d      = 1'b0;
    tag_d       = tag_q;
    empty_vld_d = 1'b0;
    found       = 1'b0;
    cnt         = 0;

    // A pending remainder always wins; a new mask is only looked at when idle.
    if (!ready)
      src = rem_q;
    else if (start)
      src = nz_mask;
    else
      src = '0;

    // Peel off the lowest set bits one lane at a time, clearing each as it is taken.
    work = src;
    for (int unsigned lane = 0; lane < MAC_DIM; lane++) begin
      found = 1'b0;
      for (int unsigned k = 0; k < SPAD_WIDTH; k++) begin
        if (!found && work[k]) begin
          found = 1'b1;
          work[k] = 1'b0;
          nz_addr_d[lane*ADDR_WIDTH +: ADDR_WIDTH] = ADDR_WIDTH'(k);
        end
      end
      if (found)
        cnt = cnt + 1;
    end

    if (src != '0) begin
      issue_vld_d = 1'b1;
      nz_num_d    = 3'(cnt - 1);
      acc_d       = !ready;
      done_d      = (work == '0);
      rem_d       = work;
      if (ready)
        tag_d = tag_in;
    end else if (ready && start) begin
      empty_vld_d = 1'b1;
      tag_d       = tag_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q       <= '0;
      issue_vld_q <= 1'b0;
      nz_addr_q   <= '0;
      nz_num_q    <= '0;
      acc_q       <= 1'b0;
      done_q      <= 1'b0;
      tag_q       <= '0;
      empty_vld_q <= 1'b0;
    end else begin
      rem_q       <= rem_d;
      issue_vld_q <= issue_vld_d;
      nz_addr_q   <= nz_addr_d;
      nz_num_q    <= nz_num_d;
      acc_q       <= acc_d;
      done_q      <= done_d;
      tag_q       <= tag_d;
      empty_vld_q <= empty_vld_d;
    end
  end

  assign issue_vld   = issue_vld_q;
  assign nz_addr_out = nz_addr_q;
  assign nz_num      = nz_num_q;
  assign acc         = acc_q;
  assign done        = done_q;
  assign tag_out     = tag_q;
  assign empty_vld   = empty_vld_q;

endmodule

// File: tb/tb_pe_nz_scheduler.sv
// Bench for pe_nz_scheduler: table of first-group vectors, hand-written corner
// sequences, and random traffic checked every cycle against a queue-based model.
module tb_pe_nz_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [63:0] nz_mask;
  logic [11:0] tag_in;
  logic        ready;
  logic        issue_vld;
  logic [35:0] nz_addr_out;
  logic [2:0]  nz_num;
  logic        acc;
  logic        done;
  logic [11:0] tag_out;
  logic        empty_vld;

  pe_nz_scheduler #(
    .MAC_DIM(6), .SPAD_WIDTH(64), .ADDR_WIDTH(6), .TAG_WIDTH(12)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .nz_mask(nz_mask), .tag_in(tag_in),
    .ready(ready), .issue_vld(issue_vld), .nz_addr_out(nz_addr_out), .nz_num(nz_num),
    .acc(acc), .done(done), .tag_out(tag_out), .empty_vld(empty_vld)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: remaining non-zero indices of the current node, oldest first.
  int          mq[$];
  logic [11:0] mtag = '0;
  logic        e_vld, e_acc, e_done, e_empty;
  logic [35:0] e_addr;
  logic [2:0]  e_num;
  logic [11:0] e_tag;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [35:0] pk(input int a0, input int a1, input int a2,
                                     input int a3, input int a4, input int a5);
    return {6'(a5), 6'(a4), 6'(a3), 6'(a2), 6'(a1), 6'(a0)};
  endfunction

  task automatic model_step();
    bit fresh;
    int n;
    fresh = 0;
    e_vld = 0; e_addr = '0; e_num = '0; e_acc = 0; e_done = 0; e_empty = 0;
    if (reset) begin
      mq.delete();
      mtag = '0;
    end else begin
      if (mq.size() == 0 && start) begin
        fresh = 1;
        mtag = tag_in;
        for (int k = 0; k < 64; k++)
          if (nz_mask[k]) mq.push_back(k);
        if (mq.size() == 0) e_empty = 1;
      end
      if (mq.size() > 0) begin
        n = (mq.size() < 6) ? mq.size() : 6;
        for (int j = 0; j < n; j++) e_addr[j*6 +: 6] = 6'(mq.pop_front());
        e_vld  = 1;
        e_num  = 3'(n - 1);
        e_acc  = !fresh;
        e_done = (mq.size() == 0);
      end
    end
    e_tag = mtag;
  endtask

  task automatic check_outs();
    chk("issue_vld", issue_vld, e_vld);
    chk("nz_addr_out", nz_addr_out, e_addr);
    chk("nz_num", nz_num, e_num);
    chk("acc", acc, e_acc);
    chk("done", done, e_done);
    chk("empty_vld", empty_vld, e_empty);
    if (e_vld || e_empty) chk("tag_out", tag_out, e_tag);
  endtask

  // One clock: check ready against the model, advance both, compare registered outputs.
  task automatic cyc();
    chk("ready", ready, mq.size() == 0);
    model_step();
    @(posedge clk);
    #1;
    check_outs();
  endtask

  typedef struct {
    logic [63:0] mask;
    logic [11:0] tag;
    logic [35:0] addr;
    logic [2:0]  num;
    logic        done;
    logic        empty;
  } vec_t;

  function automatic vec_t mkv(input logic [63:0] m, input logic [11:0] t, input logic [35:0] a,
                               input logic [2:0] n, input logic d, input logic e);
    vec_t v;
    v.mask = m; v.tag = t; v.addr = a; v.num = n; v.done = d; v.empty = e;
    return v;
  endfunction

  vec_t vt[7];

  initial begin
    int g;
    logic [35:0] last_addr;
    logic [2:0]  last_num;

    vt[0] = mkv(64'h5,                  12'd7,   pk(0, 2, 0, 0, 0, 0),      3'd1, 1'b1, 1'b0);
    vt[1] = mkv(64'hFFF,                12'd1,   pk(0, 1, 2, 3, 4, 5),      3'd5, 1'b0, 1'b0);
    vt[2] = mkv(64'h0,                  12'd3,   36'h0,                     3'd0, 1'b0, 1'b1);
    vt[3] = mkv(64'h8000_0000_0000_0000, 12'd5,  pk(63, 0, 0, 0, 0, 0),     3'd0, 1'b1, 1'b0);
    vt[4] = mkv(64'h8000_0000_0000_0001, 12'd9,  pk(0, 63, 0, 0, 0, 0),     3'd1, 1'b1, 1'b0);
    vt[5] = mkv(64'h3F << 20,           12'hABC, pk(20, 21, 22, 23, 24, 25), 3'd5, 1'b1, 1'b0);
    vt[6] = mkv(64'h7F,                 12'd2,   pk(0, 1, 2, 3, 4, 5),      3'd5, 1'b0, 1'b0);

    reset = 1; start = 0; nz_mask = '0; tag_in = '0;
    model_step();
    @(posedge clk);
    #1;
    check_outs();
    chk("reset_tag_out", tag_out, 0);
    chk("reset_ready", ready, 1);
    reset = 0;

    // Table: first group of each node, then drain under the model.
    foreach (vt[i]) begin
      start = 1; nz_mask = vt[i].mask; tag_in = vt[i].tag;
      cyc();
      start = 0;
      chk("tbl_vld", issue_vld, !vt[i].empty);
      chk("tbl_addr", nz_addr_out, vt[i].addr);
      chk("tbl_num", nz_num, vt[i].num);
      chk("tbl_acc", acc, 0);
      chk("tbl_done", done, vt[i].done);
      chk("tbl_empty", empty_vld, vt[i].empty);
      chk("tbl_tag", tag_out, vt[i].tag);
      for (int c = 0; c < 20 && !ready; c++) cyc();
      chk("tbl_drain", ready, 1);
      cyc();
    end

    // Full mask: 11 back-to-back groups, last one {60..63}.
    start = 1; nz_mask = '1; tag_in = 12'h0F0;
    cyc();
    start = 0;
    g = 0; last_addr = '0; last_num = '0;
    for (int c = 0; c < 20; c++) begin
      if (issue_vld) g++;
      if (done) begin
        last_addr = nz_addr_out; last_num = nz_num;
        break;
      end
      cyc();
    end
    chk("full_groups", g, 11);
    chk("full_last_addr", last_addr, pk(60, 61, 62, 63, 0, 0));
    chk("full_last_num", last_num, 3);
    cyc();

    // Back-to-back: B held on start, first group right after A's done group.
    start = 1; nz_mask = 64'h7F; tag_in = 12'h011;
    cyc();
    nz_mask = 64'hF0; tag_in = 12'h022;
    cyc();
    chk("b2b_a_done", done, 1);
    chk("b2b_a_tag", tag_out, 12'h011);
    cyc();
    start = 0;
    chk("b2b_b_vld", issue_vld, 1);
    chk("b2b_b_acc", acc, 0);
    chk("b2b_b_tag", tag_out, 12'h022);
    chk("b2b_b_addr", nz_addr_out, pk(4, 5, 6, 7, 0, 0));
    for (int c = 0; c < 5 && !ready; c++) cyc();
    cyc();

    // Reset during the second group of a full-mask node.
    start = 1; nz_mask = '1; tag_in = 12'h0AA;
    cyc();
    start = 0;
    cyc();
    chk("rst_mid_acc", acc, 1);
    reset = 1;
    cyc();
    reset = 0;
    chk("rst_vld", issue_vld, 0);
    chk("rst_addr", nz_addr_out, 0);
    chk("rst_done", done, 0);
    chk("rst_tag", tag_out, 0);
    chk("rst_ready", ready, 1);
    start = 1; nz_mask = 64'h5; tag_in = 12'd7;
    cyc();
    start = 0;
    chk("post_rst_addr", nz_addr_out, pk(0, 2, 0, 0, 0, 0));
    chk("post_rst_done", done, 1);
    cyc();

    // Random traffic with occasional resets and ignored starts.
    for (int c = 0; c < 600; c++) begin
      logic [63:0] a, b, m;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(0, 4))
        0: m = '0;
        1: m = a & b & {$urandom, $urandom};
        2: m = a;
        3: m = 64'h1 << $urandom_range(0, 63);
        default: m = a | b;
      endcase
      start   = ($urandom_range(0, 2) != 0);
      nz_mask = m;
      tag_in  = 12'($urandom);
      reset   = ($urandom_range(0, 39) == 0);
      cyc();
    end
    reset = 0; start = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_nz_scheduler.md
PE_NZ_SCHEDULER -- requirements
Module: pe_nz_scheduler

Interface
REQ-001 SHALL have parameter MAC_DIM, default 6: number of MAC lanes in the downstream 6-lane PE.
REQ-002 SHALL have parameter SPAD_WIDTH, default 64: number of feature/weight scratchpad entries.
REQ-003 SHALL have parameter ADDR_WIDTH, default 6: log2(SPAD_WIDTH), the width of one lane address.
REQ-004 SHALL have parameter TAG_WIDTH, default 12: width of the node tag.
REQ-005 SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port start, input, 1 bit: request to schedule one node.
REQ-008 SHALL have port nz_mask, input, SPAD_WIDTH bits: bit k set means spad entry k holds a non-zero feature.
REQ-009 SHALL have port tag_in, input, TAG_WIDTH bits: node tag, captured together with nz_mask.
REQ-010 SHALL have port ready, output, 1 bit: a start on this cycle is accepted.
REQ-011 SHALL have port issue_vld, output, 1 bit: a lane group is presented this cycle.
REQ-012 SHALL have port nz_addr_out, output, ADDR_WIDTH*MAC_DIM bits: lane j address in bits [(j+1)*ADDR_WIDTH-1 : j*ADDR_WIDTH].
REQ-013 SHALL have port nz_num, output, 3 bits: active lanes minus 1 (0 = lane 0 only, 5 = all six lanes).
REQ-014 SHALL have port acc, output, 1 bit: 0 = MAC loads a fresh sum, 1 = MAC accumulates onto the previous sum.
REQ-015 SHALL have port done, output, 1 bit: the current group is the node's last group.
REQ-016 SHALL have port tag_out, output, TAG_WIDTH bits: tag of the node being issued.
REQ-017 SHALL have port empty_vld, output, 1 bit: single-cycle pulse for a node whose mask has no set bits.

Function
REQ-018 SHALL accept a node on a rising edge where start=1 and ready=1, capturing nz_mask and tag_in.
REQ-019 SHALL hold an internal remaining-mask register rem; ready SHALL equal (rem==0) combinationally.
REQ-020 SHALL, on the edge that accepts a node with nz_mask≠0, register the first group:
- lanes 0..n-1 get the n lowest set bit indices of nz_mask in ascending order, n=min(popcount,6);
- set issue_vld=1, nz_num=n-1, acc=0, tag_out=tag_in;
- set rem = nz_mask with those n bits cleared.
REQ-021 SHALL, on every edge where rem≠0, register the next group from rem in the same way, with acc=1 and tag_out held.
REQ-022 SHALL assert done=1 on a group exactly when rem becomes 0 as a result of forming that group; done=1 with acc=0 is legal for a single-group node.
REQ-023 SHALL drive address 0 on unused lanes (j>nz_num).
REQ-024 SHALL issue exactly ceil(popcount/6) groups per node, on consecutive cycles with no bubbles.
REQ-025 SHALL support back-to-back nodes: a start accepted while the last group of the previous node is presented SHALL produce its first group on the very next cycle.
REQ-026 SHALL, when it accepts a node with nz_mask==0, pulse empty_vld=1 for one cycle with tag_out=tag_in, keep issue_vld=0, and leave ready=1.
REQ-027 SHALL drive issue_vld=0, acc=0 and done=0 on any cycle with no group; nz_addr_out and nz_num SHALL then be 0.
REQ-028 SHALL ignore start while ready=0, with no capture and no effect.
REQ-029 SHALL register all outputs except ready; latency from accepting edge to the first group SHALL be 1 cycle.

Reset
REQ-030 SHALL, on reset=1 at a rising edge, clear rem, issue_vld, nz_addr_out, nz_num, acc, done, tag_out and empty_vld to 0; ready SHALL then read 1.
REQ-031 SHALL let reset take priority over start and abandon any node mid-issue with no further groups and no done.

Verification
REQ-032 SHALL cover: mask=0x0000_0000_0000_0005, tag=7 -> 1 group: addr0=0, addr1=2, nz_num=1, acc=0, done=1, tag_out=7.
REQ-033 SHALL cover: mask=0x0000_0000_0000_0FFF -> 2 groups: {0..5} acc=0 done=0, then {6..11} acc=1 done=1, both nz_num=5, ready low for one cycle.
REQ-034 SHALL cover: mask=0xFFFF_FFFF_FFFF_FFFF -> 11 consecutive groups, the last being {60..63} with nz_num=3, done=1; unused lanes at 0.
REQ-035 SHALL cover: mask=0, tag=3 -> empty_vld pulse with tag_out=3, no issue_vld, ready stays 1.
REQ-036 SHALL cover: node A (7 bits) followed by node B held on start -> B's first group (acc=0, new tag) on the cycle after A's done group, with no gap.
REQ-037 SHALL cover: reset asserted during the 2nd group of a full-mask node -> next cycle all outputs 0, ready=1, and a subsequent start schedules normally.
